set_assoc_cache: RTL and testbench

//  2-way set-associative, write-through, write-allocate data cache between the core LSU and the

---
 rtl/set_assoc_cache_pkg.sv | 50 +++++
 rtl/set_assoc_cache_if.sv | 24 ++
 rtl/set_assoc_cache_way_array.sv | 47 ++++
 rtl/set_assoc_cache.sv | 196 +++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/set_assoc_cache_pkg.sv
// Shared types, sizes and address helpers for the 2-way set-associative data cache.
package set_assoc_cache_pkg;

    localparam int unsigned SETS        = 8;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned BE_WIDTH    = DATA_WIDTH / 8;
    localparam int unsigned WADDR_WIDTH = ADDR_WIDTH - 2;
    localparam int unsigned INDEX_WIDTH = $clog2(SETS);
    localparam int unsigned TAG_WIDTH   = WADDR_WIDTH - INDEX_WIDTH;

    typedef logic [ADDR_WIDTH-1:0]  addr_t;
    typedef logic [WADDR_WIDTH-1:0] waddr_t;
    typedef logic [INDEX_WIDTH-1:0] index_t;
    typedef logic [TAG_WIDTH-1:0]   tag_t;
    typedef logic [DATA_WIDTH-1:0]  data_t;
    typedef logic [BE_WIDTH-1:0]    be_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        MWAIT = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Core request captured on the grant edge
    typedef struct packed {
        waddr_t waddr;
        logic   we;
        be_t    be;
        data_t  wdata;
    } req_t;

    // Write payload into one way of the tag/data store
    typedef struct packed {
        index_t index;
        tag_t   tag;
        be_t    be;
        data_t  data;
    } way_wr_t;

    function automatic index_t get_index(input waddr_t waddr);
        return waddr[INDEX_WIDTH-1:0];
    endfunction

    function automatic tag_t get_tag(input waddr_t waddr);
        return waddr[WADDR_WIDTH-1:INDEX_WIDTH];
    endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// Req/gnt/rvalid word bus used on both the core side and the memory side.
interface set_assoc_cache_if import set_assoc_cache_pkg::*;;

    logic  req;
    addr_t addr;
    logic  we;
    be_t   be;
    data_t wdata;
    logic  gnt;
    logic  rvalid;
    data_t rdata;
    logic  error;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, error
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, error
    );

endinterface

// File: rtl/set_assoc_cache_way_array.sv
// One cache way: per-set valid bit, tag and data word, with byte-wise write.
module set_assoc_cache_way_array
    import set_assoc_cache_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  index_t  rd_index,
    output logic    rd_valid_c,
    output tag_t    rd_tag_c,
    output data_t   rd_data_c,
    input  logic    wr_en,
    input  way_wr_t wr
);

    logic [SETS-1:0] valid_q;
    tag_t            tag_q  [SETS];
    data_t           data_q [SETS];

    // Valid bits: cleared by reset, set by any write into the set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr.index] <= 1'b1;
        end
    end

    // Tag and data storage; only meaningful where valid is set
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr.index] <= wr.tag;
            for (int unsigned b = 0; b < BE_WIDTH; b++) begin
                if (wr.be[b]) begin
                    data_q[wr.index][b*8 +: 8] <= wr.data[b*8 +: 8];
                end
            end
        end
    end

    // Asynchronous read of the addressed set
    always_comb begin
        rd_valid_c = valid_q[rd_index];
        rd_tag_c   = tag_q[rd_index];
        rd_data_c  = data_q[rd_index];
    end

endmodule

// File: rtl/set_assoc_cache.sv
// 2-way set-associative write-through, write-allocate data cache with per-set LRU.
module set_assoc_cache
    import set_assoc_cache_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    set_assoc_cache_if.slave          core,
    set_assoc_cache_if.master         mem
);

    state_e          state_q;
    state_e          state_d;
    req_t            req_q;
    logic [SETS-1:0] lru_q;       // per set: way number of the next victim
    data_t           rdata_q;
    logic            error_q;

    waddr_t          lk_waddr;
    index_t          lk_index;
    tag_t            lk_tag;
    logic   [1:0]    way_valid;
    tag_t            way_tag  [2];
    data_t           way_data [2];
    logic   [1:0]    hit_way;
    logic            hit;
    logic            hit_sel;
    logic            victim;
    logic            grant;
    logic            mem_done;
    logic   [1:0]    way_we;
    way_wr_t         way_wr;
    logic            touch;
    logic            touch_way;

    // Tag/data storage, one instance per way
    for (genvar w = 0; w < 2; w++) begin : g_way
        set_assoc_cache_way_array u_way (
            .clk        (clk),
            .rst_n      (rst_n),
            .rd_index   (lk_index),
            .rd_valid_c (way_valid[w]),
            .rd_tag_c   (way_tag[w]),
            .rd_data_c  (way_data[w]),
            .wr_en      (way_we[w]),
            .wr         (way_wr)
        );
    end

    // Lookup: incoming address while idle, latched address afterwards
    always_comb begin
        lk_waddr  = (state_q == IDLE) ? core.addr[ADDR_WIDTH-1:2] : req_q.waddr;
        lk_index  = get_index(lk_waddr);
        lk_tag    = get_tag(lk_waddr);
        hit_way   = '0;
        for (int unsigned w = 0; w < 2; w++) begin
            hit_way[w] = way_valid[w] && (way_tag[w] == lk_tag);
        end
        hit       = |hit_way;
        hit_sel   = hit_way[1];
        // Invalid ways are filled first (way0 before way1), otherwise the LRU way
        if (!way_valid[0]) begin
            victim = 1'b0;
        end else if (!way_valid[1]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[lk_index];
        end
        grant     = core.req && (state_q == IDLE);
        mem_done  = mem.rvalid && (((state_q == MREQ) && mem.gnt) || (state_q == MWAIT));
    end

    // Cache write and LRU touch decisions
    always_comb begin
        way_we    = '0;
        way_wr    = '{index: lk_index, tag: lk_tag, be: '1, data: '0};
        touch     = 1'b0;
        touch_way = 1'b0;
        if (grant) begin
            if (core.we) begin
                if (hit) begin
                    way_we[hit_sel] = 1'b1;
                    way_wr.be       = core.be;
                    way_wr.data     = core.wdata;
                    touch           = 1'b1;
                    touch_way       = hit_sel;
                end else if (core.be == '1) begin
                    way_we[victim]  = 1'b1;
                    way_wr.data     = core.wdata;
                    touch           = 1'b1;
                    touch_way       = victim;
                end
            end else if (hit) begin
                touch     = 1'b1;
                touch_way = hit_sel;
            end
        end else if (mem_done && !req_q.we && !mem.error) begin
            way_we[victim] = 1'b1;
            way_wr.data    = mem.rdata;
            touch          = 1'b1;
            touch_way      = victim;
        end
    end

    // LRU bits: the way just used becomes MRU, the other one the victim
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lru_q <= '0;
        end else if (touch) begin
            lru_q[lk_index] <= ~touch_way;
        end
    end

    // Request latch and response data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (grant) begin
                req_q <= '{waddr: core.addr[ADDR_WIDTH-1:2], we: core.we,
                           be: core.be, wdata: core.wdata};
            end
            if (grant && !core.we && hit) begin
                rdata_q <= way_data[hit_sel];
                error_q <= 1'b0;
            end else if (mem_done) begin
                rdata_q <= req_q.we ? '0 : mem.rdata;
                error_q <= mem.error;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (core.req) begin
                    state_d = (!core.we && hit) ? RESP : MREQ;
                end
            end
            MREQ: begin
                if (mem.gnt) begin
                    state_d = mem.rvalid ? RESP : MWAIT;
                end
            end
            MWAIT: begin
                if (mem.rvalid) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs; memory side is all-zero unless a request is pending
    always_comb begin
        core.gnt    = grant;
        core.rvalid = 1'b0;
        core.rdata  = '0;
        core.error  = 1'b0;
        mem.req     = 1'b0;
        mem.addr    = '0;
        mem.we      = 1'b0;
        mem.be      = '0;
        mem.wdata   = '0;
        if (state_q == RESP) begin
            core.rvalid = 1'b1;
            core.rdata  = rdata_q;
            core.error  = error_q;
        end
        if (state_q == MREQ) begin
            mem.req   = 1'b1;
            mem.addr  = {req_q.waddr, 2'b00};
            mem.we    = req_q.we;
            mem.be    = req_q.we ? req_q.be : '1;
            mem.wdata = req_q.we ? req_q.wdata : '0;
        end
    end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench: cache against a 1-cycle word RAM model with gnt delay, same-cycle and error modes.
module tb_set_assoc_cache;

    logic clk;
    logic rst_n;

    set_assoc_cache_if core_bus ();
    set_assoc_cache_if mem_bus ();

    set_assoc_cache dut (
        .clk   (clk),
        .rst_n (rst_n),
        .core  (core_bus),
        .mem   (mem_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // ---------------- memory model ----------------
    int          n_acc      = 0;
    int          wait_cnt;
    int          gnt_delay  = 0;
    bit          fast       = 1'b0;
    bit          err_inject = 1'b0;
    int          zero_viol  = 0;
    logic        rv_q;
    logic [31:0] rd_q;
    logic        er_q;
    logic [31:0] mem_arr [1024];
    bit          written [1024];

    function automatic logic [31:0] rd_word(input logic [9:0] idx);
        return written[idx] ? mem_arr[idx] : (32'hA500_0000 | 32'(idx));
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [3:0] be,
                                               input logic [31:0] new_w);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    assign mem_bus.gnt    = mem_bus.req && (wait_cnt == gnt_delay);
    assign mem_bus.rvalid = fast ? mem_bus.gnt : rv_q;
    assign mem_bus.rdata  = fast ? rd_word(mem_bus.addr[11:2]) : rd_q;
    assign mem_bus.error  = fast ? err_inject : er_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
            rv_q     <= 1'b0;
            rd_q     <= '0;
            er_q     <= 1'b0;
        end else begin
            rv_q <= 1'b0;
            if (mem_bus.gnt) begin
                wait_cnt <= 0;
                n_acc    <= n_acc + 1;
                if (mem_bus.we) begin
                    mem_arr[mem_bus.addr[11:2]] <= merge_word(rd_word(mem_bus.addr[11:2]),
                                                              mem_bus.be, mem_bus.wdata);
                    written[mem_bus.addr[11:2]] <= 1'b1;
                end
                rv_q <= !fast;
                rd_q <= mem_bus.we ? 32'h0 : rd_word(mem_bus.addr[11:2]);
                er_q <= err_inject;
            end else if (mem_bus.req) begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !mem_bus.req &&
            (mem_bus.addr != 0 || mem_bus.we || mem_bus.be != 0 || mem_bus.wdata != 0))
            zero_viol <= zero_viol + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat, output int acc, output bit ok);
        int  a0;
        bit  granted;
        ok      = 1'b1;
        granted = 1'b0;
        rdata   = '0;
        err     = 1'b0;
        lat     = 0;
        @(negedge clk);
        core_bus.req   = 1'b1;
        core_bus.we    = we;
        core_bus.addr  = addr;
        core_bus.be    = be;
        core_bus.wdata = wdata;
        a0 = n_acc;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (core_bus.gnt) begin
                granted = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!granted) begin
            ok = 1'b0;
            core_bus.req = 1'b0;
            acc = 0;
            return;
        end
        @(posedge clk);
        #1;
        core_bus.req = 1'b0;
        ok = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (core_bus.rvalid) begin
                lat   = c;
                rdata = core_bus.rdata;
                err   = core_bus.error;
                ok    = 1'b1;
                break;
            end
        end
        acc = n_acc - a0;
    endtask

    task automatic txn_chk(input string name, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input int exp_acc, input int exp_lat);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        bit          ok;
        run_txn(we, addr, be, wdata, rdata, err, lat, acc, ok);
        chk({name, "_done"}, 32'(ok), 32'd1);
        if (ok) begin
            chk({name, "_rdata"}, rdata, exp_rdata);
            chk({name, "_error"}, 32'(err), 32'(exp_err));
            chk({name, "_memacc"}, 32'(acc), 32'(exp_acc));
            chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_acc;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input int exp_acc, input int exp_lat);
        vec_t v;
        v.we = we; v.addr = addr; v.be = be; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = 1'b0; v.exp_acc = exp_acc; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endfunction

    initial begin
        int rv_seen;

        // Hit: latency 1, no memory. Miss / write: latency 3 with the 1-cycle RAM.
        add(1, 32'h0010_0000, 4'hF, 32'h1234_ABCD, 32'h0,         1, 3); // write allocate
        add(0, 32'h0010_0000, 4'hF, 32'h0,         32'h1234_ABCD, 0, 1); // hit
        add(0, 32'h0010_0200, 4'hF, 32'h0,         32'hA500_0080, 1, 3); // set0 miss -> way1
        add(0, 32'h0010_0200, 4'hF, 32'h0,         32'hA500_0080, 0, 1);
        add(0, 32'h0010_0000, 4'hF, 32'h0,         32'h1234_ABCD, 0, 1); // make MRU
        add(0, 32'h0010_0300, 4'hF, 32'h0,         32'hA500_00C0, 1, 3); // evicts 0x200
        add(0, 32'h0010_0000, 4'hF, 32'h0,         32'h1234_ABCD, 0, 1);
        add(0, 32'h0010_0200, 4'hF, 32'h0,         32'hA500_0080, 1, 3); // was evicted
        add(0, 32'h0010_0004, 4'hF, 32'h0,         32'hA500_0001, 1, 3); // set1
        add(0, 32'h0010_0304, 4'hF, 32'h0,         32'hA500_00C1, 1, 3);
        add(0, 32'h0010_0004, 4'hF, 32'h0,         32'hA500_0001, 0, 1);
        add(0, 32'h0010_0304, 4'hF, 32'h0,         32'hA500_00C1, 0, 1);
        add(0, 32'h0010_0000, 4'hF, 32'h0,         32'h1234_ABCD, 0, 1); // set0 untouched
        add(1, 32'h0010_0408, 4'h3, 32'hDEAD_BEEF, 32'h0,         1, 3); // partial miss
        add(0, 32'h0010_0408, 4'hF, 32'h0,         32'hA500_BEEF, 1, 3); // not allocated
        add(0, 32'h0010_0408, 4'hF, 32'h0,         32'hA500_BEEF, 0, 1);
        add(1, 32'h0010_0000, 4'hC, 32'h5566_0000, 32'h0,         1, 3); // partial write hit
        add(0, 32'h0010_0000, 4'hF, 32'h0,         32'h5566_ABCD, 0, 1);

        core_bus.req   = 1'b0;
        core_bus.we    = 1'b0;
        core_bus.addr  = '0;
        core_bus.be    = '0;
        core_bus.wdata = '0;
        rst_n = 1'b0;
        #15;
        rst_n = 1'b1;

        @(negedge clk);
        chk("reset_rvalid", 32'(core_bus.rvalid), 32'd0);
        chk("reset_gnt",    32'(core_bus.gnt),    32'd0);
        chk("reset_memreq", 32'(mem_bus.req),     32'd0);
        chk("reset_rdata",  core_bus.rdata,       32'h0);

        foreach (vecs[i]) begin
            txn_chk($sformatf("v%0d", i), vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_acc, vecs[i].exp_lat);
        end

        chk("ram_word_0x000", rd_word(10'h000), 32'h5566_ABCD);
        chk("ram_word_0x408", rd_word(10'h102), 32'hA500_BEEF);

        // Delayed memory grant
        gnt_delay = 2;
        txn_chk("gnt_delay", 0, 32'h0010_0010, 4'hF, 0, 32'hA500_0004, 0, 1, 5);
        gnt_delay = 0;

        // gnt and rvalid in the same cycle
        fast = 1'b1;
        txn_chk("same_cycle", 0, 32'h0010_0014, 4'hF, 0, 32'hA500_0005, 0, 1, 2);
        txn_chk("same_cycle_hit", 0, 32'h0010_0014, 4'hF, 0, 32'hA500_0005, 0, 0, 1);
        fast = 1'b0;

        // Memory error: flagged to the core, line not filled
        err_inject = 1'b1;
        txn_chk("err_read", 0, 32'h0010_0018, 4'hF, 0, 32'hA500_0006, 1, 1, 3);
        err_inject = 1'b0;
        txn_chk("err_reread", 0, 32'h0010_0018, 4'hF, 0, 32'hA500_0006, 0, 1, 3);

        // Reset in the middle of a pending memory request
        gnt_delay = 100;
        @(negedge clk);
        core_bus.req  = 1'b1;
        core_bus.we   = 1'b0;
        core_bus.addr = 32'h0010_001C;
        #1;
        chk("rst_mid_gnt", 32'(core_bus.gnt), 32'd1);
        @(posedge clk);
        #1;
        core_bus.req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_memreq", 32'(mem_bus.req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_memreq_off", 32'(mem_bus.req), 32'd0);
        gnt_delay = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rv_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (core_bus.rvalid) rv_seen++;
        end
        chk("rst_mid_no_resp", 32'(rv_seen), 32'd0);
        txn_chk("post_rst_miss0", 0, 32'h0010_0000, 4'hF, 0, 32'h5566_ABCD, 0, 1, 3);
        txn_chk("post_rst_miss1", 0, 32'h0010_0004, 4'hF, 0, 32'hA500_0001, 0, 1, 3);
        txn_chk("post_rst_hit0",  0, 32'h0010_0000, 4'hF, 0, 32'h5566_ABCD, 0, 0, 1);

        chk("mem_idle_zero", 32'(zero_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
